// File: rtl/fir_sym_seq.sv
// Sequencer for a time-multiplexed symmetric even-length FIR filter.
// Streams (x1, x2, coeff) to an external preadder/multiplier and sums the results.
module fir_sym_seq #(
   parameter int bits      = 14,
   parameter int HALF_TAPS = 8,
   parameter int MULT_LAT  = 4,
   parameter int ACC_GUARD = 4,
   localparam int KW       = $clog2(HALF_TAPS),
   localparam int N        = 2 * HALF_TAPS,
   localparam int AW       = bits + ACC_GUARD
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic [bits-1:0] in_data_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   output logic [bits-1:0] out_data_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   input  logic            coeff_we_i,
   input  logic [KW-1:0]   coeff_addr_i,
   input  logic [17:0]     coeff_data_i,
   output logic            coeff_drop_o,
   output logic [bits-1:0] mult_x1_o,
   output logic [bits-1:0] mult_x2_o,
   output logic [17:0]     mult_coeff_o,
   input  logic [bits-1:0] mult_y_i,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   state_t              state, state_n;
   logic [KW-1:0]       k;
   logic [bits-1:0]     d [N];
   logic [17:0]         coef [HALF_TAPS];
   logic signed [AW-1:0] acc, acc_sum;
   logic                mv, ml;
   logic [MULT_LAT-1:0] vpipe, lpipe;
   logic                accept, last_k, done;
   logic [ACC_GUARD:0]  top;
   logic [bits-1:0]     sat_v;

   assign accept = (state == IDLE) & in_valid_i & in_ready_o;
   assign last_k = (k == KW'(HALF_TAPS - 1));
   // lpipe marks only the final product, so it also implies vpipe
   assign done   = lpipe[MULT_LAT-1];
   assign busy_o = (state != IDLE);

   assign acc_sum = acc + $signed({{ACC_GUARD{mult_y_i[bits-1]}}, mult_y_i});
   assign top     = acc_sum[AW-1:bits-1];

   always_comb begin
      sat_v = acc_sum[bits-1:0];
      if (!((&top) || !(|top))) begin
         if (top[ACC_GUARD]) sat_v = {1'b1, {(bits-1){1'b0}}};
         else                sat_v = {1'b0, {(bits-1){1'b1}}};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (accept)      state_n = MAC;
         MAC:   if (last_k)      state_n = DRAIN;
         DRAIN: if (done)        state_n = OUT;
         OUT:   if (out_ready_i) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         in_ready_o   <= 1'b0;
         out_data_o   <= '0;
         out_valid_o  <= 1'b0;
         coeff_drop_o <= 1'b0;
         mult_x1_o    <= '0;
         mult_x2_o    <= '0;
         mult_coeff_o <= '0;
         k            <= '0;
         acc          <= '0;
         mv           <= 1'b0;
         ml           <= 1'b0;
         vpipe        <= '0;
         lpipe        <= '0;
         for (int j = 0; j < N; j++) d[j] <= '0;
         for (int j = 0; j < HALF_TAPS; j++) coef[j] <= '0;
      end else begin
         in_ready_o <= (state_n == IDLE);
         mv         <= (state == MAC);
         ml         <= (state == MAC) && last_k;
         vpipe      <= {vpipe[MULT_LAT-2:0], mv};
         lpipe      <= {lpipe[MULT_LAT-2:0], ml};
         if (vpipe[MULT_LAT-1]) acc <= acc_sum;
         if (accept) begin
            d[0] <= in_data_i;
            for (int j = 1; j < N; j++) d[j] <= d[j-1];
            acc <= '0;
            k   <= '0;
         end
         // ~{0,k} is N-1-k: the mirrored tap
         if (state == MAC) begin
            mult_x1_o    <= d[k];
            mult_x2_o    <= d[~{1'b0, k}];
            mult_coeff_o <= coef[k];
            k            <= k + 1'b1;
         end
         if (coeff_we_i) begin
            if (busy_o) coeff_drop_o <= 1'b1;
            else        coef[coeff_addr_i] <= coeff_data_i;
         end
         if (state == DRAIN && done) begin
            out_data_o  <= sat_v;
            out_valid_o <= 1'b1;
         end else if (state == OUT && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_sym_seq.sv
// Randomized self-checking bench for fir_sym_seq.
// Models the external multiplier and a direct-form reference filter.
module tb_fir_sym_seq;

   localparam int HT = 8;
   localparam int N  = 16;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [13:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic signed [13:0] out_data;
   logic out_valid;
   logic out_ready = 1'b0;
   logic coeff_we = 1'b0;
   logic [2:0] coeff_addr = '0;
   logic [17:0] coeff_data = '0;
   logic coeff_drop;
   logic signed [13:0] mult_x1, mult_x2, mult_y;
   logic signed [17:0] mult_coeff;
   logic busy;

   int total = 0;
   int bad = 0;

   logic signed [13:0] hist [N];
   logic signed [17:0] cm [HT];
   logic signed [13:0] yp [4] = '{default: '0};

   always #5 clk = ~clk;

   fir_sym_seq dut (
      .clk_i(clk), .rstn_i(rstn),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .coeff_we_i(coeff_we), .coeff_addr_i(coeff_addr),
      .coeff_data_i(coeff_data), .coeff_drop_o(coeff_drop),
      .mult_x1_o(mult_x1), .mult_x2_o(mult_x2), .mult_coeff_o(mult_coeff),
      .mult_y_i(mult_y), .busy_o(busy)
   );

   function automatic logic signed [13:0] sat14(input longint v);
      if (v > 8191) return 14'sd8191;
      if (v < -8192) return -14'sd8192;
      return v[13:0];
   endfunction

   function automatic logic signed [13:0] mult_f(input logic signed [13:0] a,
                                                 input logic signed [13:0] b,
                                                 input logic signed [17:0] c);
      longint p;
      p = (longint'(a) + longint'(b)) * longint'(c);
      return sat14(p >>> 17);
   endfunction

   // external multiplier: result appears MULT_LAT cycles after operands
   always @(posedge clk) begin
      yp[0] <= mult_f(mult_x1, mult_x2, mult_coeff);
      for (int i = 1; i < 4; i++) yp[i] <= yp[i-1];
   end
   assign mult_y = yp[3];

   function automatic logic signed [13:0] golden();
      longint s = 0;
      for (int t = 0; t < HT; t++) s += longint'(mult_f(hist[t], hist[N-1-t], cm[t]));
      return sat14(s);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) hist[i] = '0;
      for (int i = 0; i < HT; i++) cm[i] = '0;
   endtask

   task automatic model_push(input logic signed [13:0] x);
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
   endtask

   task automatic wr_coef(input int a, input int v);
      @(negedge clk);
      coeff_we = 1'b1;
      coeff_addr = 3'(a);
      coeff_data = 18'(v);
      @(negedge clk);
      coeff_we = 1'b0;
      cm[a] = 18'(v);
   endtask

   task automatic run_sample(input logic signed [13:0] x, input int stall,
                             input int wr_at, output logic signed [13:0] y,
                             output int lat, output bit rdy_ok, output bit hold_ok);
      int n;
      rdy_ok = 1'b1;
      hold_ok = 1'b1;
      lat = 0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_data = x;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_push(x);
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         coeff_we = (wr_at > 0) && (lat == wr_at);
         if (out_valid) break;
         if (in_ready) rdy_ok = 1'b0;
      end
      coeff_we = 1'b0;
      if (!out_valid) lat = -1;
      y = out_data;
      repeat (stall) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || out_data !== y) hold_ok = 1'b0;
         if (in_ready) rdy_ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      if (out_valid) hold_ok = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, busy, coeff_drop} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0000", {out_valid, in_ready, busy, coeff_drop});
      end
      total++;
      if (out_data !== 0 || mult_x1 !== 0 || mult_x2 !== 0 || mult_coeff !== 0) begin
         bad++;
         $display("FAIL reset_data got out=%0d x1=%0d x2=%0d c=%0d exp=0",
                  out_data, mult_x1, mult_x2, mult_coeff);
      end
      @(negedge clk) rstn = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_impulse(input int pass);
      logic signed [13:0] y, e;
      int lat;
      bit r, h;
      wr_coef(0, 65536);
      for (int i = 1; i < HT; i++) wr_coef(i, 0);
      for (int n = 0; n <= 20; n++) begin
         run_sample((n == 0) ? 14'sd1000 : 14'sd0, 0, 0, y, lat, r, h);
         e = (n == 0 || n == 15) ? 14'sd500 : 14'sd0;
         total++;
         if (y !== e || lat < 0) begin
            bad++;
            $display("FAIL impulse pass=%0d n=%0d got=%0d exp=%0d lat=%0d", pass, n, y, e, lat);
         end
      end
   endtask

   task automatic test_latency();
      logic signed [13:0] y, e;
      int lat;
      bit r, h;
      for (int i = 0; i < HT; i++) wr_coef(i, int'($urandom_range(0, 80000)) - 40000);
      for (int n = 0; n < 4; n++) begin
         run_sample(14'($urandom), 0, 0, y, lat, r, h);
         e = golden();
         total++;
         if (lat !== 13 || !r) begin
            bad++;
            $display("FAIL latency n=%0d got=%0d ready_ok=%0b exp=13 ready_ok=1", n, lat, r);
         end
         total++;
         if (y !== e) begin
            bad++;
            $display("FAIL latency_data n=%0d got=%0d exp=%0d", n, y, e);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [13:0] y, e, v;
      int lat;
      bit r, h;
      for (int i = 0; i < HT; i++) wr_coef(i, 131071);
      for (int p = 0; p < 2; p++) begin
         v = (p == 0) ? 14'sd8191 : -14'sd8192;
         for (int n = 0; n < N; n++) begin
            run_sample(v, 0, 0, y, lat, r, h);
            e = golden();
            total++;
            if (y !== e) begin
               bad++;
               $display("FAIL sat_model p=%0d n=%0d got=%0d exp=%0d", p, n, y, e);
            end
         end
         total++;
         if (y !== v) begin
            bad++;
            $display("FAIL sat_final p=%0d got=%0d exp=%0d", p, y, v);
         end
      end
   endtask

   task automatic test_backpressure();
      logic signed [13:0] y, e;
      int lat;
      bit r, h;
      for (int n = 0; n < 2; n++) begin
         run_sample(14'($urandom), 20, 0, y, lat, r, h);
         e = golden();
         total++;
         if (y !== e || !r || !h) begin
            bad++;
            $display("FAIL backpressure n=%0d got=%0d ready_ok=%0b hold_ok=%0b exp=%0d 1 1",
                     n, y, r, h, e);
         end
      end
   endtask

   task automatic test_coeff_drop();
      logic signed [13:0] y, e;
      int lat;
      bit r, h;
      total++;
      if (coeff_drop !== 1'b0) begin
         bad++;
         $display("FAIL drop_pre got=%b exp=0", coeff_drop);
      end
      coeff_addr = 3'd0;
      coeff_data = 18'(-5000);
      run_sample(14'($urandom), 0, 3, y, lat, r, h);
      e = golden();
      total++;
      if (coeff_drop !== 1'b1) begin
         bad++;
         $display("FAIL drop_flag got=%b exp=1", coeff_drop);
      end
      total++;
      if (y !== e) begin
         bad++;
         $display("FAIL drop_data got=%0d exp=%0d", y, e);
      end
      run_sample(14'($urandom), 0, 0, y, lat, r, h);
      e = golden();
      total++;
      if (y !== e || coeff_drop !== 1'b1) begin
         bad++;
         $display("FAIL drop_after got=%0d flag=%b exp=%0d 1", y, coeff_drop, e);
      end
   endtask

   task automatic test_mid_reset();
      int seen;
      @(negedge clk);
      in_data = 14'sd3000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b0;
      #1;
      total++;
      if ({out_valid, busy, in_ready, coeff_drop} !== 4'b0) begin
         bad++;
         $display("FAIL midrst_flags got=%b exp=0000", {out_valid, busy, in_ready, coeff_drop});
      end
      @(negedge clk) rstn = 1'b1;
      model_clear();
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL midrst_noout got=%0d exp=0", seen);
      end
   endtask

   task automatic test_random();
      logic signed [13:0] y, e;
      int lat;
      bit r, h;
      for (int i = 0; i < HT; i++) wr_coef(i, int'($urandom_range(0, 131070)) - 65535);
      for (int n = 0; n < 24; n++) begin
         run_sample(14'($urandom), int'($urandom_range(0, 2)), 0, y, lat, r, h);
         e = golden();
         total++;
         if (y !== e || lat !== 13 || !h) begin
            bad++;
            $display("FAIL random n=%0d got=%0d lat=%0d hold=%0b exp=%0d 13 1", n, y, lat, h, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse(0);
      test_latency();
      test_saturation();
      test_backpressure();
      test_coeff_drop();
      test_random();
      test_mid_reset();
      test_impulse(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
